// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer.
//   state_e      : FSM state encodings (also visible on dbg_state)
//   OP_*         : IR[6:0] opcodes understood by the sequencer
//   RES_/SRCA_/SRCB_/ALUOP_/IMM_* : select codes driven onto the datapath muxes
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StBeq      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // States in which the sequencer is waiting on the memory handshake.
    function automatic logic is_mem_wait_state(state_e s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate-format select decoded straight from the IR opcode.
// Ports:
//   i_opcode   [6:0]  IR[6:0]
//   o_imm_src  [1:0]  00 = I-format (lw, I-type, default), 01 = S (sw), 10 = B (beq)
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [1:0] o_imm_src
);

    always_comb begin
        o_imm_src = IMM_I;
        case (i_opcode)
            OP_SW:   o_imm_src = IMM_S;
            OP_BEQ:  o_imm_src = IMM_B;
            default: o_imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multi-cycle RV32I core (lw, sw, R-type, beq, optional I-type).
// Walks the instruction through its states and drives the PC/IR/register-file/memory strobes and
// the ALU/result mux selects. Memory states stall on i_mem_ready; a stall reaching MEM_WAIT_MAX
// cycles pulses o_mem_timeout and abandons the access (FETCH retries in place).
// Configuration: define MC_ITYPE_EN to make opcode 0010011 legal (DECODE -> EXECI -> ALUWB).
// Ports:
//   i_clk, i_rst (async, active high)
//   i_opcode [6:0], i_zero, i_mem_ready
//   o_pc_write, o_adr_src, o_ir_write, o_mem_write, o_reg_write       strobes / address select
//   o_result_src, o_alu_src_a, o_alu_src_b, o_alu_op, o_imm_src [1:0] datapath selects
//   o_illegal_op, o_mem_timeout                                       one-cycle event pulses
//   o_dbg_state [STATE_W-1:0]                                         current state encoding
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W      = 4,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [6:0]         i_opcode,
    input  logic               i_zero,
    input  logic               i_mem_ready,
    output logic               o_pc_write,
    output logic               o_adr_src,
    output logic               o_ir_write,
    output logic               o_mem_write,
    output logic               o_reg_write,
    output logic [1:0]         o_result_src,
    output logic [1:0]         o_alu_src_a,
    output logic [1:0]         o_alu_src_b,
    output logic [1:0]         o_alu_op,
    output logic [1:0]         o_imm_src,
    output logic               o_illegal_op,
    output logic               o_mem_timeout,
    output logic [STATE_W-1:0] o_dbg_state
);

    localparam int unsigned CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam bit               TIMEOUT_EN = (MEM_WAIT_MAX > 0);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             w_wait_state;
    logic             w_timeout;
    logic             w_illegal;
    logic [1:0]       w_imm_src;

    // A ready in the same cycle as the limit completes the access, so it suppresses the timeout.
    always_comb begin
        w_wait_state = is_mem_wait_state(r_state);
        w_timeout    = TIMEOUT_EN && w_wait_state && !i_mem_ready && (r_wait_cnt == WAIT_LIMIT);
    end

    always_comb begin
        w_state_next = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            StFetch: begin
                if (i_mem_ready) w_state_next = StDecode;
            end
            StDecode: begin
                case (i_opcode)
                    OP_LW, OP_SW: w_state_next = StMemAdr;
                    OP_R:         w_state_next = StExecR;
                    OP_BEQ:       w_state_next = StBeq;
`ifdef MC_ITYPE_EN
                    OP_I:         w_state_next = StExecI;
`endif
                    default: begin
                        w_state_next = StFetch;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            StMemAdr: w_state_next = (i_opcode == OP_SW) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (i_mem_ready)    w_state_next = StMemWb;
                else if (w_timeout) w_state_next = StFetch;
            end
            StMemWb: w_state_next = StFetch;
            StMemWrite: begin
                if (i_mem_ready || w_timeout) w_state_next = StFetch;
            end
            StExecR: w_state_next = StAluWb;
`ifdef MC_ITYPE_EN
            StExecI: w_state_next = StAluWb;
`endif
            StAluWb: w_state_next = StFetch;
            StBeq:   w_state_next = StFetch;
            default: w_state_next = StFetch;
        endcase
    end

    // Counts stalled cycles only; any completion, timeout or state change restarts it.
    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if ((w_state_next != r_state) || !w_wait_state || i_mem_ready || w_timeout) begin
            w_wait_cnt_next = '0;
        end else if (r_wait_cnt != CNT_SAT) begin
            w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StFetch;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    imm_src_decoder u_imm_src_decoder (
        .i_opcode  (i_opcode),
        .o_imm_src (w_imm_src)
    );

    // Moore decode; i_rst gates everything so no strobe escapes while reset is held.
    always_comb begin
        o_pc_write    = 1'b0;
        o_adr_src     = 1'b0;
        o_ir_write    = 1'b0;
        o_mem_write   = 1'b0;
        o_reg_write   = 1'b0;
        o_result_src  = RES_ALUOUT;
        o_alu_src_a   = SRCA_PC;
        o_alu_src_b   = SRCB_RS2;
        o_alu_op      = ALUOP_ADD;
        o_imm_src     = IMM_I;
        o_illegal_op  = 1'b0;
        o_mem_timeout = 1'b0;
        if (!i_rst) begin
            o_imm_src     = w_imm_src;
            o_illegal_op  = w_illegal;
            o_mem_timeout = w_timeout;
            case (r_state)
                StFetch: begin
                    o_alu_src_b  = SRCB_FOUR;
                    o_result_src = RES_ALU;
                    o_ir_write   = i_mem_ready;
                    o_pc_write   = i_mem_ready;
                end
                StDecode: begin
                    o_alu_src_a = SRCA_OLDPC;
                    o_alu_src_b = SRCB_IMM;
                end
                StMemAdr: begin
                    o_alu_src_a = SRCA_RS1;
                    o_alu_src_b = SRCB_IMM;
                end
                StMemRead: begin
                    o_adr_src = 1'b1;
                end
                StMemWb: begin
                    o_result_src = RES_DATA;
                    o_reg_write  = 1'b1;
                end
                StMemWrite: begin
                    o_adr_src   = 1'b1;
                    o_mem_write = 1'b1;
                end
                StExecR: begin
                    o_alu_src_a = SRCA_RS1;
                    o_alu_op    = ALUOP_FUNCT;
                end
`ifdef MC_ITYPE_EN
                StExecI: begin
                    o_alu_src_a = SRCA_RS1;
                    o_alu_src_b = SRCB_IMM;
                    o_alu_op    = ALUOP_FUNCT;
                end
`endif
                StAluWb: begin
                    o_reg_write = 1'b1;
                end
                StBeq: begin
                    o_alu_src_a = SRCA_RS1;
                    o_alu_op    = ALUOP_SUB;
                    o_pc_write  = i_zero;
                end
                default: begin
                    o_imm_src = IMM_I;
                end
            endcase
        end
    end

    assign o_dbg_state = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomised bench for multicycle_control_fsm with an instruction-level reference model,
// plus directed sequences pinned by hand-computed literal expectations.
module tb_multicycle_control_fsm;

    localparam int WAIT_MAX = 15;
    localparam int CNT_CAP  = 15;
`ifdef MC_ITYPE_EN
    localparam bit ITYPE = 1'b1;
`else
    localparam bit ITYPE = 1'b0;
`endif

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] IT  = 7'b0010011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal_op, mem_timeout;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] dbg_state;

    multicycle_control_fsm #(
        .STATE_W      (4),
        .MEM_WAIT_MAX (WAIT_MAX)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_opcode      (opcode),
        .i_zero        (zero),
        .i_mem_ready   (mem_ready),
        .o_pc_write    (pc_write),
        .o_adr_src     (adr_src),
        .o_ir_write    (ir_write),
        .o_mem_write   (mem_write),
        .o_reg_write   (reg_write),
        .o_result_src  (result_src),
        .o_alu_src_a   (alu_src_a),
        .o_alu_src_b   (alu_src_b),
        .o_alu_op      (alu_op),
        .o_imm_src     (imm_src),
        .o_illegal_op  (illegal_op),
        .o_mem_timeout (mem_timeout),
        .o_dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Bit layout: [20]pc_write [19]adr_src [18]ir_write [17]mem_write [16]reg_write
    // [15:14]result_src [13:12]alu_src_a [11:10]alu_src_b [9:8]alu_op [7:6]imm_src
    // [5]illegal_op [4]mem_timeout [3:0]dbg_state
    logic [20:0] dut_vec;
    assign dut_vec = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, alu_src_a,
                      alu_src_b, alu_op, imm_src, illegal_op, mem_timeout, dbg_state};

    int          n_pass = 0;
    int          n_total = 0;
    int          m_state = 0;
    int          m_cnt = 0;
    logic [20:0] cap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit op_legal(input logic [6:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || ((op == IT) && ITYPE);
    endfunction

    function automatic bit model_timeout();
        bit waiting = (m_state == 0) || (m_state == 3) || (m_state == 5);
        return waiting && !mem_ready && (WAIT_MAX > 0) && (m_cnt == WAIT_MAX);
    endfunction

    // Expected outputs for the current model state and current inputs.
    function automatic logic [20:0] model_out();
        logic       pcw = 0, adr = 0, irw = 0, mw = 0, rw = 0, ill = 0, to = 0;
        logic [1:0] res = 0, sa = 0, sb = 0, op = 0, imm = 0;
        logic [3:0] st = 0;
        if (!rst) begin
            st  = m_state[3:0];
            imm = (opcode == SW) ? 2'b01 : (opcode == BEQ) ? 2'b10 : 2'b00;
            to  = model_timeout();
            case (m_state)
                0:  begin sb = 2'b10; res = 2'b10; pcw = mem_ready; irw = mem_ready; end
                1:  begin sa = 2'b01; sb = 2'b01; ill = !op_legal(opcode); end
                2:  begin sa = 2'b10; sb = 2'b01; end
                3:  adr = 1'b1;
                4:  begin res = 2'b01; rw = 1'b1; end
                5:  begin adr = 1'b1; mw = 1'b1; end
                6:  begin sa = 2'b10; op = 2'b10; end
                7:  rw = 1'b1;
                8:  begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
                10: begin sa = 2'b10; op = 2'b01; pcw = zero; end
                default: ;
            endcase
        end
        return {pcw, adr, irw, mw, rw, res, sa, sb, op, imm, ill, to, st};
    endfunction

    function automatic void model_advance();
        int nxt;
        bit waiting;
        bit to;
        if (rst) begin
            m_state = 0;
            m_cnt   = 0;
            return;
        end
        waiting = (m_state == 0) || (m_state == 3) || (m_state == 5);
        to      = model_timeout();
        nxt     = m_state;
        case (m_state)
            0: if (mem_ready) nxt = 1;
            1: begin
                if ((opcode == LW) || (opcode == SW)) nxt = 2;
                else if (opcode == RT)                nxt = 6;
                else if (opcode == BEQ)               nxt = 10;
                else if ((opcode == IT) && ITYPE)     nxt = 8;
                else                                  nxt = 0;
            end
            2: nxt = (opcode == SW) ? 5 : 3;
            3: nxt = mem_ready ? 4 : (to ? 0 : 3);
            5: nxt = (mem_ready || to) ? 0 : 5;
            6, 8: nxt = 7;
            default: nxt = 0;
        endcase
        if ((nxt != m_state) || !waiting || mem_ready || to) m_cnt = 0;
        else if (m_cnt < CNT_CAP) m_cnt++;
        m_state = nxt;
    endfunction

    // One clock cycle: drive, compare mid-cycle, advance model, move past the next edge.
    task automatic step(input logic r, input logic [6:0] op, input logic z, input logic rdy);
        rst       = r;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        #4;
        cap = dut_vec;
        check("cycle", 32'(dut_vec), 32'(model_out()));
        model_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] seq;
        logic [5:0]  rws;
        int          cnt_a;
        int          cnt_b;
        int          first;
        int          mode;
        logic [6:0]  cur_op;
        logic        rdy;

        @(posedge clk);
        #1;
        // Reset: ready high must not leak through as a FETCH strobe.
        step(1'b1, LW, 1'b1, 1'b1);
        check("reset_state", 32'(cap[3:0]), 32'd0);
        check("reset_outputs", 32'(cap[20:4]), 32'd0);

        // lw with memory always ready.
        seq = '0;
        rws = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, LW, 1'b0, 1'b1);
            seq = {seq[19:0], cap[3:0]};
            rws = {rws[4:0], cap[16]};
            if (i == 4) check("lw_result_src", 32'(cap[15:14]), 32'b01);
        end
        check("lw_states", 32'(seq), 32'h012340);
        check("lw_reg_write", 32'(rws), 32'b000010);

        // beq taken then not taken (currently in DECODE).
        step(1'b0, BEQ, 1'b1, 1'b1);
        step(1'b0, BEQ, 1'b1, 1'b1);
        check("beq_taken_pcw", 32'(cap[20]), 32'd1);
        check("beq_taken_aluop", 32'(cap[9:8]), 32'b01);
        step(1'b0, BEQ, 1'b0, 1'b1);
        step(1'b0, BEQ, 1'b0, 1'b1);
        step(1'b0, BEQ, 1'b0, 1'b1);
        check("beq_not_taken_pcw", 32'(cap[20]), 32'd0);
        check("beq_not_taken_aluop", 32'(cap[9:8]), 32'b01);

        // sw with three stall cycles.
        cnt_a = 0;
        step(1'b0, SW, 1'b0, 1'b1);
        step(1'b0, SW, 1'b0, 1'b1);
        step(1'b0, SW, 1'b0, 1'b1);
        cnt_a += int'(cap[17]);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, SW, 1'b0, (i == 3));
            cnt_a += int'(cap[17]);
        end
        check("sw_mem_write_cycles", 32'(cnt_a), 32'd4);
        step(1'b0, LW, 1'b0, 1'b1);
        check("sw_then_fetch", 32'(cap[3:0]), 32'd0);

        // lw stuck in MEMREAD until timeout (currently in DECODE).
        step(1'b0, LW, 1'b0, 1'b1);
        step(1'b0, LW, 1'b0, 1'b1);
        cnt_a = 0;
        cnt_b = 0;
        first = -1;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, LW, 1'b0, 1'b0);
            if (cap[4]) begin
                cnt_a++;
                if (first < 0) first = i;
            end
            cnt_b += int'(cap[16]);
        end
        check("timeout_cycle", 32'(first), 32'd15);
        check("timeout_pulses", 32'(cnt_a), 32'd1);
        step(1'b0, IT, 1'b0, 1'b1);
        check("timeout_to_fetch", 32'(cap[3:0]), 32'd0);
        check("timeout_no_writeback", 32'(cnt_b + int'(cap[16])), 32'd0);

        // I-type opcode (currently in DECODE).
        step(1'b0, IT, 1'b0, 1'b1);
`ifdef MC_ITYPE_EN
        check("itype_legal", 32'(cap[5]), 32'd0);
        step(1'b0, IT, 1'b0, 1'b1);
        check("itype_exec", 32'(cap[3:0]), 32'd8);
        step(1'b0, IT, 1'b0, 1'b1);
        check("itype_wb", 32'({cap[3:0], cap[16]}), 32'({4'd7, 1'b1}));
`else
        check("itype_illegal", 32'(cap[5]), 32'd1);
        step(1'b0, IT, 1'b0, 1'b0);
        check("itype_back_to_fetch", 32'(cap[3:0]), 32'd0);
`endif

        // Reset in the middle of a stalled store (from FETCH).
        step(1'b0, SW, 1'b0, 1'b1);
        step(1'b0, SW, 1'b0, 1'b1);
        step(1'b0, SW, 1'b0, 1'b1);
        step(1'b0, SW, 1'b0, 1'b0);
        check("pre_reset_mem_write", 32'(cap[17]), 32'd1);
        step(1'b1, SW, 1'b1, 1'b0);
        check("reset_mem_write", 32'(cap[17]), 32'd0);
        check("reset_mid_state", 32'(cap[3:0]), 32'd0);
        step(1'b1, SW, 1'b1, 1'b1);
        check("reset_no_strobes", 32'({cap[20], cap[18:16], cap[5:4]}), 32'd0);

        // Randomised traffic against the model.
        mode   = 0;
        cur_op = LW;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) mode = int'($urandom_range(0, 2));
            if (m_state == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    cur_op = LW;
                    2, 3:    cur_op = SW;
                    4, 5:    cur_op = RT;
                    6:       cur_op = BEQ;
                    7:       cur_op = IT;
                    default: cur_op = 7'($urandom);
                endcase
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else                rdy = ($urandom_range(0, 24) == 0);
            step(($urandom_range(0, 299) == 0), cur_op, 1'($urandom_range(0, 1)), rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
